dcache_disp_buf: RTL and testbench

//  Displacement (writeback) buffer between dcache_pipe and the L2 disp port.

---
 rtl/dcache_disp_buf_pkg.sv | 27 ++
 rtl/dcache_disp_buf_fifo.sv | 42 ++++
 rtl/dcache_disp_buf.sv | 93 +++++++++
 tb/tb_dcache_disp_buf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_disp_buf_pkg.sv
// Shared types for the dcache displacement (writeback) path toward L2.
package dcache_disp_buf_pkg;

   localparam int L1_REQID_W = 5;
   localparam int L2_REQID_W = 6;
   localparam int MASK_W     = 8;
   localparam int DCMD_W     = 3;
   localparam int PPADDR_W   = 34;
   localparam int LINE_W     = 512;

   typedef logic [L1_REQID_W-1:0] L1_reqid_type;
   typedef logic [L2_REQID_W-1:0] L2_reqid_type;
   typedef logic [MASK_W-1:0]     SC_disp_mask_type;
   typedef logic [DCMD_W-1:0]     SC_dcmd_type;
   typedef logic [PPADDR_W-1:0]   SC_ppaddr_type;
   typedef logic [LINE_W-1:0]     SC_line_type;

   typedef struct packed {
      L1_reqid_type     l1id;
      L2_reqid_type     l2id;
      SC_disp_mask_type mask;
      SC_dcmd_type      dcmd;
      SC_line_type      line;
      SC_ppaddr_type    ppaddr;
   } I_l1tol2_disp_type;

endpackage

// File: rtl/dcache_disp_buf_fifo.sv
// Generic DEPTH-entry FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate count.
module dcache_disp_buf_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; validity comes only from the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dcache_disp_buf.sv
// Displacement buffer: in-order FIFO from dcache_pipe to L2 plus per-id
// in-flight tracking until the matching dack returns.
module dcache_disp_buf
   import dcache_disp_buf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int L1ID_W = 5,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dctodb_disp_valid,
   output logic              dctodb_disp_retry,
   input  I_l1tol2_disp_type dctodb_disp,
   output logic              l1tol2_disp_valid,
   input  logic              l1tol2_disp_retry,
   output I_l1tol2_disp_type l1tol2_disp,
   input  logic              l2tol1_dack_valid,
   output logic              l2tol1_dack_retry,
   input  logic [L1ID_W-1:0] l2tol1_dack_l1id,
   output logic [CNT_W-1:0]  db_outstanding,
   output logic              db_idle,
   output logic              db_dack_err
);

   // Every port transfers when valid && !retry; a sender under retry holds
   // its payload stable, and a receiver may drop retry at any time.

   localparam int NID = 2**L1ID_W;

   logic           full;
   logic           empty;
   logic           enq;
   logic           deq;
   logic           dack_ok;
   logic [NID-1:0] busy_q;
   logic [NID-1:0] busy_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic           err_q;

   // Retry uses only registered state plus the offered id, never L2 inputs.
   assign dctodb_disp_retry = full | busy_q[dctodb_disp.l1id];
   assign enq               = dctodb_disp_valid & ~dctodb_disp_retry;
   assign l1tol2_disp_valid = ~empty;
   assign deq               = l1tol2_disp_valid & ~l1tol2_disp_retry;
   assign dack_ok           = l2tol1_dack_valid & busy_q[l2tol1_dack_l1id];
   assign l2tol1_dack_retry = 1'b0;

   dcache_disp_buf_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(I_l1tol2_disp_type))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (enq),
      .wr_data (dctodb_disp),
      .rd_en   (deq),
      .rd_data (l1tol2_disp),
      .full    (full),
      .empty   (empty)
   );

   // Enqueue and dack never name the same id in one cycle, so order is moot.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (dack_ok) busy_d[l2tol1_dack_l1id] = 1'b0;
      if (enq)     busy_d[dctodb_disp.l1id] = 1'b1;
      case ({enq, dack_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         if (l2tol1_dack_valid && !busy_q[l2tol1_dack_l1id]) err_q <= 1'b1;
      end
   end

   assign db_outstanding = cnt_q;
   assign db_idle        = empty & (cnt_q == '0);
   assign db_dack_err    = err_q;

endmodule

// File: tb/tb_dcache_disp_buf.sv
// Directed bench for dcache_disp_buf: ordering, id blocking, dack error, reset.
module tb_dcache_disp_buf;
   import dcache_disp_buf_pkg::*;

   localparam int CNT_W = 6;

   logic              clk;
   logic              reset;
   logic              dv;
   logic              dretry;
   I_l1tol2_disp_type din;
   logic              ov;
   logic              oretry;
   I_l1tol2_disp_type dout;
   logic              dkv;
   logic              dkretry;
   logic [4:0]        dkid;
   logic [CNT_W-1:0]  outstanding;
   logic              idle;
   logic              err;

   int total = 0;
   int bad   = 0;
   logic [639:0] exp_q[$];

   dcache_disp_buf #(.DEPTH(4), .L1ID_W(5), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .dctodb_disp_valid (dv),
      .dctodb_disp_retry (dretry),
      .dctodb_disp       (din),
      .l1tol2_disp_valid (ov),
      .l1tol2_disp_retry (oretry),
      .l1tol2_disp       (dout),
      .l2tol1_dack_valid (dkv),
      .l2tol1_dack_retry (dkretry),
      .l2tol1_dack_l1id  (dkid),
      .db_outstanding    (outstanding),
      .db_idle           (idle),
      .db_dack_err       (err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic I_l1tol2_disp_type mk(input int id);
      I_l1tol2_disp_type p;
      logic [31:0] w;
      w        = 32'hdead0000 ^ (32'(id) * 32'h01010101);
      p.l1id   = 5'(id);
      p.l2id   = 6'(id + 1);
      p.mask   = 8'(8'h80 >> (id % 8));
      p.dcmd   = 3'(id % 5);
      p.line   = {16{w}};
      p.ppaddr = 34'h2_0000_0000 | 34'(id * 64);
      return p;
   endfunction

   task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change on the negedge, checks 1ns later
   task automatic enq(input int id);
      @(negedge clk);
      dv  = 1'b1;
      din = mk(id);
      #1 check("enq_ready", 640'(dretry), 640'(0));
      exp_q.push_back(640'(mk(id)));
      @(posedge clk);
      #1 dv = 1'b0;
   endtask

   // Checks the head without advancing the bench clock.
   task automatic pop_check(input string tag);
      logic [639:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_v"}, 640'(ov), 640'(1));
      check({tag, "_d"}, 640'(dout), e);
   endtask

   task automatic dack(input int id);
      @(negedge clk);
      dkv  = 1'b1;
      dkid = 5'(id);
      @(posedge clk);
      #1 dkv = 1'b0;
   endtask

   initial begin
      reset = 1'b0; dv = 1'b0; din = mk(0); oretry = 1'b0; dkv = 1'b0; dkid = '0;
      #12;
      check("rst_ov", 640'(ov), 640'(0));
      check("rst_retry", 640'(dretry), 640'(0));
      check("rst_cnt", 640'(outstanding), 640'(0));
      check("rst_idle", 640'(idle), 640'(1));
      check("rst_err", 640'(err), 640'(0));
      check("rst_dkretry", 640'(dkretry), 640'(0));
      @(negedge clk); reset = 1'b1;

      // 1: single displacement, one-cycle latency, dack returns to idle
      @(negedge clk);
      #1 check("t1_empty", 640'(ov), 640'(0));
      enq(3);
      @(negedge clk);
      #1 pop_check("t1_out");
      check("t1_cnt1", 640'(outstanding), 640'(1));
      check("t1_busy_idle", 640'(idle), 640'(0));
      @(negedge clk);
      #1 check("t1_drained", 640'(ov), 640'(0));
      check("t1_cnt_hold", 640'(outstanding), 640'(1));
      dack(3);
      @(negedge clk);
      #1 check("t1_cnt0", 640'(outstanding), 640'(0));
      check("t1_idle", 640'(idle), 640'(1));
      check("t1_err", 640'(err), 640'(0));

      // 2: fill under L2 retry, full blocks, strict order on drain
      oretry = 1'b1;
      for (int i = 0; i < 4; i++) enq(i);
      @(negedge clk);
      dv = 1'b1; din = mk(4);
      #1 check("t2_full_retry", 640'(dretry), 640'(1));
      check("t2_cnt4", 640'(outstanding), 640'(4));
      @(negedge clk);
      oretry = 1'b0;
      #1 check("t2_full_deq_retry", 640'(dretry), 640'(1));
      pop_check("t2_o0");
      @(negedge clk);
      #1 check("t2_slot_free", 640'(dretry), 640'(0));
      pop_check("t2_o1");
      exp_q.push_back(640'(mk(4)));
      @(posedge clk);
      #1 dv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 pop_check("t2_drain");
      end
      @(negedge clk);
      #1 check("t2_empty", 640'(ov), 640'(0));
      check("t2_cnt5", 640'(outstanding), 640'(5));
      for (int i = 0; i < 5; i++) dack(i);
      @(negedge clk);
      #1 check("t2_cnt0", 640'(outstanding), 640'(0));

      // 3: busy id blocks re-offer until its dack, no comb path from dack
      enq(7);
      @(negedge clk);
      dv = 1'b1; din = mk(7);
      #1 check("t3_busy_retry", 640'(dretry), 640'(1));
      pop_check("t3_first");
      @(negedge clk);
      dkv = 1'b1; dkid = 5'd7;
      #1 check("t3_retry_with_dack", 640'(dretry), 640'(1));
      @(negedge clk);
      dkv = 1'b0;
      #1 check("t3_reaccept", 640'(dretry), 640'(0));
      exp_q.push_back(640'(mk(7)));
      @(posedge clk);
      #1 dv = 1'b0;
      @(negedge clk);
      #1 pop_check("t3_second");
      check("t3_cnt1", 640'(outstanding), 640'(1));
      dack(7);

      // 4: dack for an idle id is sticky error, no state change
      dack(9);
      @(negedge clk);
      #1 check("t4_err", 640'(err), 640'(1));
      check("t4_cnt", 640'(outstanding), 640'(0));
      @(negedge clk);
      #1 check("t4_err_sticky", 640'(err), 640'(1));

      // 5: enqueue id 2 and dack id 5 in the same cycle
      enq(5);
      @(negedge clk);
      #1 pop_check("t5_o5");
      dv = 1'b1; din = mk(2); dkv = 1'b1; dkid = 5'd5;
      #1 check("t5_enq_ready", 640'(dretry), 640'(0));
      exp_q.push_back(640'(mk(2)));
      @(posedge clk);
      #1 begin dv = 1'b0; dkv = 1'b0; end
      @(negedge clk);
      #1 check("t5_cnt", 640'(outstanding), 640'(1));
      pop_check("t5_o2");
      din = mk(2);
      #1 check("t5_busy2", 640'(dretry), 640'(1));
      din = mk(5);
      #1 check("t5_free5", 640'(dretry), 640'(0));
      dack(2);

      // 6: reset with entries queued discards everything
      oretry = 1'b1;
      for (int i = 1; i < 4; i++) enq(i);
      @(negedge clk);
      #1 check("t6_cnt3", 640'(outstanding), 640'(3));
      din = mk(1);
      reset = 1'b0;
      #1 check("t6_rst_ov", 640'(ov), 640'(0));
      check("t6_rst_retry", 640'(dretry), 640'(0));
      check("t6_rst_cnt", 640'(outstanding), 640'(0));
      check("t6_rst_idle", 640'(idle), 640'(1));
      check("t6_rst_err", 640'(err), 640'(0));
      exp_q.delete();
      @(negedge clk);
      reset  = 1'b1;
      oretry = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check("t6_no_stale", 640'(ov), 640'(0));
         check("t6_idle", 640'(idle), 640'(1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
